// File: rtl/seq_alu_if.sv
// Start/busy/done request bundle between the ALU control (master) and seq_alu (slave).
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUSelection;
    logic             cmp_unsigned;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, ALUSelection, cmp_unsigned, A, B,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, ALUSelection, cmp_unsigned, A, B,
        output busy, done, result, zero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, one-bit-per-cycle iterative shifter.
//
// state  | meaning
// IDLE   | waiting for start; the only state in which a request is accepted
// SHIFT  | iterative shift, one bit per cycle, counter counts down to 1
// FINISH | publish work register to result/zero and pulse done
module seq_alu #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_LT   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] work;

    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             lt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;

    assign shamt    = bus.B[SHW-1:0];
    assign is_shift = (bus.ALUSelection == OP_SLL) || (bus.ALUSelection == OP_SRL) ||
                      (bus.ALUSelection == OP_SRA);
    assign bus.busy = (state != IDLE);

    always_comb begin
        lt = bus.cmp_unsigned ? (bus.A < bus.B) : ($signed(bus.A) < $signed(bus.B));
    end

    always_comb begin
        alu_res = '0;
        case (bus.ALUSelection)
            OP_ADD:  alu_res = bus.A + bus.B;
            OP_SUB:  alu_res = bus.A - bus.B;
            OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_XOR:  alu_res = bus.A ^ bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_AND:  alu_res = bus.A & bus.B;
            default: alu_res = '0;
        endcase
    end

    // Direction comes from the latched opcode so the bus may change mid-shift.
    always_comb begin
        shifted = work;
        case (op_q)
            OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            cnt        <= '0;
            work       <= '0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.zero   <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.ALUSelection;
                        if (is_shift) begin
                            work <= bus.A;
                            if (shamt == '0) begin
                                state <= FINISH;
                            end else begin
                                cnt   <= shamt;
                                state <= SHIFT;
                            end
                        end else begin
                            work  <= alu_res;
                            state <= FINISH;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.result <= work;
                    bus.zero   <= (work == '0);
                    bus.done   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
